// File: rtl/fwd_sel_gen_pkg.sv
// Shared select codes and scoreboard-entry type for the forwarding-select generator.
package fwd_sel_gen_pkg;

  // Widest register address a scoreboard entry can hold; narrower RA_W is zero-extended.
  localparam int RA_MAX = 8;

  // One-hot operand-mux select codes (all-zero picks the register file).
  localparam logic [4:0] SEL_RF     = 5'b00000;
  localparam logic [4:0] SEL_E_ALU  = 5'b10000;
  localparam logic [4:0] SEL_M      = 5'b01000;
  localparam logic [4:0] SEL_W      = 5'b00100;
  localparam logic [4:0] SEL_E_LINK = 5'b00010;
  localparam logic [4:0] SEL_M_LOAD = 5'b00001;

  typedef struct packed {
    logic              vld;
    logic [RA_MAX-1:0] wreg;
    logic              is_load;
    logic              is_link;
  } sb_entry_t;

endpackage

// File: rtl/fwd_sel_gen_pick.sv
// fwd_pick: single-operand forwarding priority resolver (purely combinational).
import fwd_sel_gen_pkg::*;

module fwd_pick #(
  parameter int FWD_R0 = 0
) (
  input  logic [RA_MAX-1:0] s,
  input  sb_entry_t         e,
  input  sb_entry_t         m,
  input  sb_entry_t         w,
  output logic [4:0]        sel,
  output logic              lu
);

  logic nz, hit_e, hit_m, hit_w;
  logic unused_ok;

  assign nz    = (s != '0) || (FWD_R0 != 0);
  assign hit_e = e.vld && (e.wreg == s) && nz;
  assign hit_m = m.vld && (m.wreg == s) && nz;
  assign hit_w = w.vld && (w.wreg == s) && nz;
  assign unused_ok = &{1'b0, m.is_link, w.is_load, w.is_link};

  // Youngest stage first; an E-stage load cannot forward yet, so it requests a stall.
  always_comb begin
    sel = SEL_RF;
    lu  = 1'b0;
    if (hit_e) begin
      if (e.is_link)      sel = SEL_E_LINK;
      else if (!e.is_load) sel = SEL_E_ALU;
      else                lu  = 1'b1;
    end else if (hit_m) begin
      sel = m.is_load ? SEL_M_LOAD : SEL_M;
    end else if (hit_w) begin
      sel = SEL_W;
    end
  end

endmodule

// File: rtl/fwd_sel_gen.sv
// fwd_sel_gen: E/M/W write scoreboard driving rs/rt forwarding selects and load-use stall.
// Optional FWD_STATS_EN adds saturating stall / forward counters.
import fwd_sel_gen_pkg::*;

module fwd_sel_gen #(
  parameter int RA_W   = 5,
  parameter int SEL_W  = 5,
  parameter int FWD_R0 = 0
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [RA_W-1:0]  d_rs,
  input  logic [RA_W-1:0]  d_rt,
  input  logic             d_wen,
  input  logic [RA_W-1:0]  d_wreg,
  input  logic             d_is_load,
  input  logic             d_is_link,
  input  logic             flush_e,
  input  logic             stall_all,
  output logic [SEL_W-1:0] sel_rs,
  output logic [SEL_W-1:0] sel_rt,
  output logic             stall_d
`ifdef FWD_STATS_EN
  ,
  output logic [31:0]      stat_stall,
  output logic [31:0]      stat_fwd_e,
  output logic [31:0]      stat_fwd_mw
`endif
);

  if (SEL_W != 5) begin : g_bad_sel_w
    $error("fwd_sel_gen: SEL_W must be 5");
  end
  if (RA_W > RA_MAX) begin : g_bad_ra_w
    $error("fwd_sel_gen: RA_W exceeds RA_MAX");
  end

  sb_entry_t sb_e, sb_m, sb_w, d_ent;
  logic lu_rs, lu_rt;

  assign d_ent = '{vld: d_wen, wreg: RA_MAX'(d_wreg), is_load: d_is_load, is_link: d_is_link};

  fwd_pick #(.FWD_R0(FWD_R0)) u_pick_rs (
    .s(RA_MAX'(d_rs)), .e(sb_e), .m(sb_m), .w(sb_w), .sel(sel_rs), .lu(lu_rs)
  );
  fwd_pick #(.FWD_R0(FWD_R0)) u_pick_rt (
    .s(RA_MAX'(d_rt)), .e(sb_e), .m(sb_m), .w(sb_w), .sel(sel_rt), .lu(lu_rt)
  );

  assign stall_d = (lu_rs || lu_rt) && !stall_all;

  // Scoreboard shift: hold on global stall, otherwise advance with a bubble into E on flush/load-use.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sb_e <= '0;
      sb_m <= '0;
      sb_w <= '0;
    end else if (!stall_all) begin
      sb_w <= sb_m;
      sb_m <= sb_e;
      sb_e <= (flush_e || stall_d) ? '0 : d_ent;
    end
  end

`ifdef FWD_STATS_EN
  logic fwd_e_hit, fwd_mw_hit;
  assign fwd_e_hit  = (sel_rs == SEL_E_ALU) || (sel_rs == SEL_E_LINK) ||
                      (sel_rt == SEL_E_ALU) || (sel_rt == SEL_E_LINK);
  assign fwd_mw_hit = (sel_rs == SEL_M) || (sel_rs == SEL_M_LOAD) || (sel_rs == SEL_W) ||
                      (sel_rt == SEL_M) || (sel_rt == SEL_M_LOAD) || (sel_rt == SEL_W);

  // Saturating event counters, frozen while the pipeline is frozen.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stat_stall  <= '0;
      stat_fwd_e  <= '0;
      stat_fwd_mw <= '0;
    end else if (!stall_all) begin
      if (stall_d    && stat_stall  != '1) stat_stall  <= stat_stall  + 32'd1;
      if (fwd_e_hit  && stat_fwd_e  != '1) stat_fwd_e  <= stat_fwd_e  + 32'd1;
      if (fwd_mw_hit && stat_fwd_mw != '1) stat_fwd_mw <= stat_fwd_mw + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fwd_sel_gen.sv
// Directed self-checking bench for fwd_sel_gen (default build).
module tb_fwd_sel_gen;

  logic       clk = 1'b0;
  logic       resetn;
  logic [4:0] d_rs, d_rt, d_wreg;
  logic       d_wen, d_is_load, d_is_link, flush_e, stall_all;
  logic [4:0] sel_rs, sel_rt;
  logic       stall_d;
  int         total = 0;
  int         bad = 0;
`ifdef FWD_STATS_EN
  logic [31:0] stat_stall, stat_fwd_e, stat_fwd_mw;
`endif

  always #5 clk = ~clk;

  fwd_sel_gen dut (
    .clk(clk), .resetn(resetn), .d_rs(d_rs), .d_rt(d_rt), .d_wen(d_wen),
    .d_wreg(d_wreg), .d_is_load(d_is_load), .d_is_link(d_is_link),
    .flush_e(flush_e), .stall_all(stall_all),
    .sel_rs(sel_rs), .sel_rt(sel_rt), .stall_d(stall_d)
`ifdef FWD_STATS_EN
    , .stat_stall(stat_stall), .stat_fwd_e(stat_fwd_e), .stat_fwd_mw(stat_fwd_mw)
`endif
  );

  task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Decode-stage inputs: rs, rt, wen, wreg, load, link.
  task automatic drv(input logic [4:0] rs, rt, input logic wen, input logic [4:0] wreg,
                     input logic ld, lk);
    d_rs = rs; d_rt = rt; d_wen = wen; d_wreg = wreg; d_is_load = ld; d_is_link = lk;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    resetn = 1'b0; flush_e = 1'b0; stall_all = 1'b0;
    drv(0, 0, 0, 0, 0, 0);

    // Reset held with random decode inputs: outputs stay at the register-file code.
    for (int i = 0; i < 3; i++) begin
      drv(5'($urandom), 5'($urandom), 1'($urandom), 5'($urandom), 1'($urandom), 1'($urandom));
      settle();
      chk("rst_sel_rs", sel_rs, 5'b00000);
      chk("rst_sel_rt", sel_rt, 5'b00000);
      chk("rst_stall",  {4'b0, stall_d}, 5'b00000);
      tick();
    end
    drv(0, 0, 0, 0, 0, 0);
    resetn = 1'b1;
    tick();
    drv(3, 5, 0, 0, 0, 0); settle();
    chk("empty_rs", sel_rs, 5'b00000);
    chk("empty_rt", sel_rt, 5'b00000);

    // ALU chain on r3 walking E -> M -> W -> out.
    drv(0, 0, 1, 3, 0, 0); tick();
    drv(3, 0, 0, 0, 0, 0); settle();
    chk("alu_e", sel_rs, 5'b10000);
    tick();
    chk("alu_m", sel_rs, 5'b01000);
    tick();
    chk("alu_w", sel_rs, 5'b00100);
    tick();
    chk("alu_rf", sel_rs, 5'b00000);

    // Load-use on r5: one stall cycle, then M load data.
    drv(0, 0, 1, 5, 1, 0); tick();
    drv(0, 5, 1, 6, 0, 0); settle();
    chk("lu_stall1", {4'b0, stall_d}, 5'b00001);
    chk("lu_sel1",   sel_rt, 5'b00000);
    tick();
    chk("lu_stall2", {4'b0, stall_d}, 5'b00000);
    chk("lu_sel2",   sel_rt, 5'b00001);
    drv(0, 0, 0, 0, 0, 0); tick(); tick(); tick();

    // Link in E over an ALU r31 in M; r0 never forwards.
    drv(0, 0, 1, 31, 0, 0); tick();
    drv(0, 0, 1, 31, 0, 1); tick();
    drv(31, 0, 1, 0, 0, 0); settle();
    chk("link_e", sel_rs, 5'b00010);
    chk("r0_rt",  sel_rt, 5'b00000);
    chk("link_nostall", {4'b0, stall_d}, 5'b00000);
    tick();
    drv(31, 31, 0, 0, 0, 0); settle();
    chk("both_rs_m", sel_rs, 5'b01000);
    chk("both_rt_m", sel_rt, 5'b01000);
    drv(31, 0, 0, 0, 0, 0); settle();
    chk("r0_e_write", sel_rt, 5'b00000);
    tick(); tick(); tick();

    // Freeze with an E load on r7 (ALU r7 in M), then flush E.
    drv(0, 0, 1, 7, 0, 0); tick();
    drv(0, 0, 1, 7, 1, 0); tick();
    drv(7, 0, 0, 0, 0, 0);
    stall_all = 1'b1;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("frz_stall", {4'b0, stall_d}, 5'b00000);
      chk("frz_sel",   sel_rs, 5'b00000);
      tick();
    end
    stall_all = 1'b0; flush_e = 1'b1; settle();
    chk("pre_flush_stall", {4'b0, stall_d}, 5'b00001);
    tick();
    flush_e = 1'b0; settle();
    chk("flush_m_load", sel_rs, 5'b00001);
    chk("flush_nostall", {4'b0, stall_d}, 5'b00000);
    tick();
    chk("flush_w", sel_rs, 5'b00100);
    tick(); tick();

    // Asynchronous reset mid-cycle clears an E-stage entry at once.
    drv(0, 0, 1, 9, 0, 0); tick();
    drv(9, 9, 0, 0, 0, 0); settle();
    chk("pre_arst", sel_rs, 5'b10000);
    #2 resetn = 1'b0; settle();
    chk("arst_rs", sel_rs, 5'b00000);
    chk("arst_rt", sel_rt, 5'b00000);
    tick();
    resetn = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    bad++;
    $display("FAIL timeout observed=running expected=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
